// File: rtl/scan_pkg.sv
// scan_pkg: shared constants for the matrix scan path (FSM encoding, sync bytes, matrix size, FIFO entry layout)
package scan_pkg;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SYNC0 = 3'd1;
  localparam logic [2:0] ST_SYNC1 = 3'd2;
  localparam logic [2:0] ST_FID   = 3'd3;
  localparam logic [2:0] ST_SHI   = 3'd4;
  localparam logic [2:0] ST_SLO   = 3'd5;
  localparam logic [2:0] ST_CSUM  = 3'd6;
  localparam logic [7:0] SYNC0_DEF = 8'hFF;
  localparam logic [7:0] SYNC1_DEF = 8'hA5;
  localparam int DIMX_DEF = 31;
  localparam int DIMY_DEF = 128;
  localparam int X_W = 5;
  localparam int Y_W = 9;
  localparam int D_W = 16;
  typedef struct packed {
    logic           sof;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [D_W-1:0] data;
  } entry_t;
  localparam int ENTRY_W = $bits(entry_t);
endpackage

// File: rtl/scan_sample_fifo.sv
// scan_sample_fifo: synchronous FIFO, async active-high reset.
// Ports: clk_i, rst_i, push_i/wdata_i (write), pop_i/rdata_o (show-ahead read), full_o, empty_o.
// A push on a full FIFO succeeds when a pop happens in the same cycle.
module scan_sample_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign rdata_o = mem_q[rptr_q];
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop) rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk_i)
    if (do_push) mem_q[wptr_q] <= wdata_i;
endmodule

// File: rtl/scan_frame_packer.sv
// scan_frame_packer: captures tagged ADC samples and frames them into a UART byte stream.
// Ports: clock, reset (async, active-high); head_in, sample_valid, sample_data, col_x, row_y (capture side);
//        tx_data, tx_valid, tx_ready (byte handshake); frame_cnt, overflow, coord_err, frame_err, busy (status).
// Frame: SYNC0 SYNC1 frame_cnt {hi,lo} x DIMX*DIMY [xor checksum when SCAN_PACK_CHECKSUM_EN is defined].
module scan_frame_packer
  import scan_pkg::*;
#(
  parameter int         DIMX       = DIMX_DEF,
  parameter int         DIMY       = DIMY_DEF,
  parameter int         DATA_W     = 12,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] SYNC0      = SYNC0_DEF,
  parameter logic [7:0] SYNC1      = SYNC1_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              head_in,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [X_W-1:0]    col_x,
  input  logic [Y_W-1:0]    row_y,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [7:0]        frame_cnt,
  output logic              overflow,
  output logic              coord_err,
  output logic              frame_err,
  output logic              busy
);
  localparam int NCELL = DIMX * DIMY;
  localparam int IW = $clog2(NCELL + 1);
`ifdef SCAN_PACK_CHECKSUM_EN
  localparam logic [2:0] ST_END = ST_CSUM;
`else
  localparam logic [2:0] ST_END = ST_IDLE;
`endif
  logic [2:0] state_q, state_d;
  logic head_q, sof_pend_q;
  logic [IW-1:0] idx_q;
  logic [X_W-1:0] ex_q;
  logic [Y_W-1:0] ey_q;
  logic [7:0] fcnt_q;
  logic ovf_q, cerr_q, ferr_q;
  entry_t wr, rd;
  logic full, empty, push, pop, xfer, start, early, last, frame_done;
  assign wr = {sof_pend_q, col_x, row_y, D_W'(sample_data)};
  assign push = sample_valid && (!full || pop);
  assign xfer = tx_valid && tx_ready;
  assign start = state_q == ST_IDLE && !empty && rd.sof;
  // a new sof entry reaching the head mid-frame restarts the frame without consuming it
  assign early = state_q == ST_SHI && !empty && rd.sof && idx_q != '0;
  assign last = idx_q == IW'(NCELL - 1);
  // entries seen in IDLE without sof belong to no frame and are discarded
  assign pop = (state_q == ST_IDLE && !empty && !rd.sof) || (state_q == ST_SLO && xfer);
  assign busy = state_q != ST_IDLE;
  assign frame_cnt = fcnt_q;
  assign overflow = ovf_q;
  assign coord_err = cerr_q;
  assign frame_err = ferr_q;
`ifdef SCAN_PACK_CHECKSUM_EN
  logic [7:0] csum_q;
  assign frame_done = state_q == ST_CSUM && xfer;
  always_ff @(posedge clock or posedge reset)
    if (reset) csum_q <= '0;
    else if (state_q == ST_SYNC0) csum_q <= '0;
    else if (xfer && (state_q == ST_FID || state_q == ST_SHI || state_q == ST_SLO)) csum_q <= csum_q ^ tx_data;
`else
  assign frame_done = state_q == ST_SLO && xfer && last;
`endif
  scan_sample_fifo #(.W(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i(clock),
    .rst_i(reset),
    .push_i(push),
    .pop_i(pop),
    .wdata_i(wr),
    .rdata_o(rd),
    .full_o(full),
    .empty_o(empty)
  );
  always_comb begin
    tx_valid = 1'b1;
    tx_data = 8'h00;
    case (state_q)
      ST_SYNC0: tx_data = SYNC0;
      ST_SYNC1: tx_data = SYNC1;
      ST_FID:   tx_data = fcnt_q;
      ST_SHI: begin
        tx_valid = !empty && !early;
        tx_data = rd.data[D_W-1:8];
      end
      ST_SLO:   tx_data = rd.data[7:0];
`ifdef SCAN_PACK_CHECKSUM_EN
      ST_CSUM:  tx_data = csum_q;
`endif
      default:  tx_valid = 1'b0;
    endcase
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = start ? ST_SYNC0 : ST_IDLE;
      ST_SYNC0: state_d = xfer ? ST_SYNC1 : ST_SYNC0;
      ST_SYNC1: state_d = xfer ? ST_FID : ST_SYNC1;
      ST_FID:   state_d = xfer ? ST_SHI : ST_FID;
      ST_SHI:   state_d = early ? ST_SYNC0 : xfer ? ST_SLO : ST_SHI;
      ST_SLO:   state_d = !xfer ? ST_SLO : last ? ST_END : ST_SHI;
`ifdef SCAN_PACK_CHECKSUM_EN
      ST_CSUM:  state_d = xfer ? ST_IDLE : ST_CSUM;
`endif
      default:  state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= ST_IDLE;
      head_q <= 1'b0;
      sof_pend_q <= 1'b0;
      idx_q <= '0;
      ex_q <= '0;
      ey_q <= '0;
      fcnt_q <= '0;
      ovf_q <= 1'b0;
      cerr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q <= head_in;
      // a dropped sample leaves the pending frame start for the next accepted one
      sof_pend_q <= (head_in && !head_q) || (sof_pend_q && !push);
      if (state_q == ST_SYNC0) begin
        idx_q <= '0;
        ex_q <= '0;
        ey_q <= '0;
      end else if (state_q == ST_SLO && xfer) begin
        idx_q <= idx_q + IW'(1);
        ex_q <= ex_q == X_W'(DIMX - 1) ? '0 : ex_q + X_W'(1);
        ey_q <= ex_q == X_W'(DIMX - 1) ? ey_q + Y_W'(1) : ey_q;
      end
      if (frame_done) fcnt_q <= fcnt_q + 8'd1;
      if (sample_valid && !push) ovf_q <= 1'b1;
      cerr_q <= start ? 1'b0 : cerr_q || (state_q == ST_SLO && xfer && (rd.x != ex_q || rd.y != ey_q));
      ferr_q <= start ? 1'b0 : ferr_q || early;
    end
endmodule
